// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the load/store stage
// Purpose: size encodings, FSM state enum and byte-enable constants used by
//          mem_access_stage and mem_lane_align.
// Ports:   none (package).
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is handled as a word too

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane steering and load extract/extend
// Purpose: purely combinational. Produces byte enables and lane-replicated
//          write data for stores, and the extracted, extended load value.
// Ports:
//   size_i       access size (SZ_*); 2'b11 behaves as a word
//   off_i        byte offset within the word (addr[1:0])
//   sign_ext_i   loads: 1 sign-extend, 0 zero-extend
//   store_data_i raw store data (low bits used for byte/half)
//   rdata_i      raw RAM read word
//   be_o         byte enables for the store
//   wdata_o      replicated store data
//   load_o       extracted and extended load result
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sign_ext_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rdata_i[{off_i, 3'b000} +: 8];
  // Half lane is picked by off[1] only, so an odd half offset is forced aligned.
  assign ld_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = store_data_i;
    load_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE0 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
        load_o  = {{24{sign_ext_i & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be_o    = off_i[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata_o = {2{store_data_i[15:0]}};
        load_o  = {{16{sign_ext_i & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store stage driving a synchronous single-port RAM
// Purpose: accepts one ALU result per transaction, performs at most one RAM
//          access (load or store), and returns the result to writeback.
//          Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word
//          accesses are flagged and skip the RAM). Undefined: offsets below
//          the access size are ignored and misalign is always 0.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           upstream handshake (ready only in IDLE)
//   mem_read, mem_write         op select (write wins)
//   size, sign_ext              access size, load extension
//   alu_result, store_data      byte address or pass-through value, store data
//   rd_in                       destination tag carried to out_rd
//   ram_addr/wdata/be/we/re     registered RAM request
//   ram_rdata                   RAM read data, valid the cycle after ram_re
//   out_valid/out_ready         writeback handshake
//   out_data, out_rd, misalign  result, held stable while out_valid
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rd_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              misalign
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [3:0]          ram_be_q, ram_be_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_re_q, ram_re_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [4:0]          out_rd_q, out_rd_d;
  logic                misalign_q, misalign_d;
  logic                op_load_q, op_load_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic                sign_q, sign_d;

  logic                access_misaligned;
  logic [1:0]          align_size;
  logic [1:0]          align_off;
  logic [3:0]          align_be;
  logic [DATA_W-1:0]   align_wdata;
  logic [DATA_W-1:0]   align_load;

`ifdef MEM_ALIGN_CHECK_EN
  // size[1] covers both the word encoding and the 2'b11 alias.
  assign access_misaligned = ((size == SZ_HALF) && alu_result[0]) ||
                             (size[1] && (alu_result[1:0] != 2'b00));
`else
  assign access_misaligned = 1'b0;
`endif

  // Store steering is needed at acceptance (from live inputs); load extraction
  // is needed in WAIT (from the latched op), so one aligner serves both.
  assign align_size = (state_q == ST_IDLE) ? size : size_q;
  assign align_off  = (state_q == ST_IDLE) ? alu_result[1:0] : off_q;

  mem_lane_align u_lane_align (
    .size_i       (align_size),
    .off_i        (align_off),
    .sign_ext_i   (sign_q),
    .store_data_i (store_data),
    .rdata_i      (ram_rdata),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .load_o       (align_load)
  );

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    misalign_d  = misalign_q;
    op_load_d   = op_load_q;
    size_d      = size_q;
    off_d       = off_q;
    sign_d      = sign_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          out_rd_d   = rd_in;
          size_d     = size;
          off_d      = alu_result[1:0];
          sign_d     = sign_ext;
          misalign_d = 1'b0;
          op_load_d  = 1'b0;
          if (!(mem_read || mem_write)) begin
            state_d     = ST_RESP;
            out_valid_d = 1'b1;
            out_data_d  = alu_result;
          end else if (access_misaligned) begin
            state_d     = ST_RESP;
            out_valid_d = 1'b1;
            out_data_d  = '0;
            misalign_d  = 1'b1;
          end else begin
            state_d    = ST_ACCESS;
            ram_addr_d = alu_result[ADDR_W+1:2];
            ram_be_d   = align_be;
            if (mem_write) begin
              ram_we_d    = 1'b1;
              ram_wdata_d = align_wdata;
            end else begin
              ram_re_d  = 1'b1;
              op_load_d = 1'b1;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (op_load_q) begin
          state_d = ST_WAIT;
        end else begin
          state_d     = ST_RESP;
          out_valid_d = 1'b1;
          out_data_d  = '0;
        end
      end
      ST_WAIT: begin
        state_d     = ST_RESP;
        out_valid_d = 1'b1;
        out_data_d  = align_load;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          misalign_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= BE_NONE;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      misalign_q  <= 1'b0;
      op_load_q   <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      misalign_q  <= misalign_d;
      op_load_q   <= op_load_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sign_q      <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_be    = ram_be_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        misalign;

  mem_access_stage #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .sign_ext   (sign_ext),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_in      (rd_in),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_be     (ram_be),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: read data appears the cycle after ram_re.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_mis;
    int          exp_lat;
    int          exp_we;
    int          exp_re;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  vec_t tv[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t base(input logic [4:0] rd);
    vec_t v;
    v.rd_op = 1'b0; v.wr_op = 1'b0; v.sz = 2'b10; v.sx = 1'b0;
    v.addr = 32'h0; v.sdata = 32'h0; v.rd = rd; v.exp_data = 32'h0; v.exp_mis = 1'b0;
    v.exp_lat = 1; v.exp_we = 0; v.exp_re = 0; v.exp_addr = 10'h0; v.exp_be = 4'h0;
    v.exp_wdata = 32'h0;
    return v;
  endfunction

  function automatic vec_t st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] rd, input logic [9:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd);
    vec_t v = base(rd);
    v.wr_op = 1'b1; v.sz = sz; v.addr = addr; v.sdata = sdata;
    v.exp_lat = 2; v.exp_we = 1; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
    return v;
  endfunction

  function automatic vec_t ld(input logic [1:0] sz, input logic sx, input logic [31:0] addr,
                              input logic [4:0] rd, input logic [31:0] ed, input logic [9:0] ea);
    vec_t v = base(rd);
    v.rd_op = 1'b1; v.sz = sz; v.sx = sx; v.addr = addr;
    v.exp_lat = 3; v.exp_re = 1; v.exp_addr = ea; v.exp_data = ed;
    return v;
  endfunction

  function automatic vec_t nm(input logic [31:0] alu, input logic [4:0] rd);
    vec_t v = base(rd);
    v.addr = alu; v.exp_data = alu;
    return v;
  endfunction

  function automatic vec_t mis(input logic r, input logic w, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
    vec_t v = base(rd);
    v.rd_op = r; v.wr_op = w; v.sz = sz; v.addr = addr; v.sdata = sdata; v.exp_mis = 1'b1;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int lat, nwe, nre;
    logic [9:0]  waddr, raddr;
    logic [3:0]  be;
    logic [31:0] wd;
    exp_t e;
    lat = 0; nwe = 0; nre = 0; waddr = '0; raddr = '0; be = '0; wd = '0;
    in_valid = 1'b1; mem_read = v.rd_op; mem_write = v.wr_op; size = v.sz; sign_ext = v.sx;
    alu_result = v.addr; store_data = v.sdata; rd_in = v.rd; out_ready = 1'b1;
    e.data = v.exp_data; e.rd = v.rd; e.mis = v.exp_mis;
    exp_q.push_back(e);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (ram_we) begin nwe++; waddr = ram_addr; be = ram_be; wd = ram_wdata; end
      if (ram_re) begin nre++; raddr = ram_addr; end
      if (out_valid) lat = c;
    end
    chk($sformatf("latency_rd%0d", v.rd), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("we_pulses_rd%0d", v.rd), 32'(nwe), 32'(v.exp_we));
    chk($sformatf("re_pulses_rd%0d", v.rd), 32'(nre), 32'(v.exp_re));
    if (v.exp_we != 0) begin
      chk($sformatf("st_addr_rd%0d", v.rd), {22'b0, waddr}, {22'b0, v.exp_addr});
      chk($sformatf("st_be_rd%0d", v.rd), {28'b0, be}, {28'b0, v.exp_be});
      chk($sformatf("st_wdata_rd%0d", v.rd), wd, v.exp_wdata);
    end
    if (v.exp_re != 0)
      chk($sformatf("ld_addr_rd%0d", v.rd), {22'b0, raddr}, {22'b0, v.exp_addr});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every writeback handshake pops one expected result.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_out: got out_data 0x%08h expected no result", out_data);
      end else begin
        e_m = exp_q.pop_front();
        chk("out_data", out_data, e_m.data);
        chk("out_rd", {27'b0, out_rd}, {27'b0, e_m.rd});
        chk("misalign", {31'b0, misalign}, {31'b0, e_m.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    sign_ext = 1'b0; alu_result = 32'h0; store_data = 32'h0; rd_in = 5'h0; out_ready = 1'b1;

    tv.push_back(st(2'b10, 32'h10, 32'h8001_0000, 5'd1, 10'd4, 4'hF, 32'h8001_0000));
    tv.push_back(ld(2'b01, 1'b0, 32'h12, 5'd2, 32'h0000_8001, 10'd4));
    tv.push_back(ld(2'b01, 1'b1, 32'h12, 5'd3, 32'hFFFF_8001, 10'd4));
    tv.push_back(ld(2'b01, 1'b1, 32'h10, 5'd4, 32'h0000_0000, 10'd4));
    tv.push_back(st(2'b10, 32'h10, 32'hDEAD_BEEF, 5'd5, 10'd4, 4'hF, 32'hDEAD_BEEF));
    tv.push_back(st(2'b00, 32'h13, 32'h1234_56A5, 5'd6, 10'd4, 4'h8, 32'hA5A5_A5A5));
    tv.push_back(ld(2'b00, 1'b1, 32'h13, 5'd7, 32'hFFFF_FFA5, 10'd4));
    tv.push_back(ld(2'b00, 1'b0, 32'h13, 5'd8, 32'h0000_00A5, 10'd4));
    tv.push_back(ld(2'b00, 1'b1, 32'h11, 5'd9, 32'hFFFF_FFBE, 10'd4));
    tv.push_back(st(2'b01, 32'h16, 32'hFFFF_CAFE, 5'd10, 10'd5, 4'hC, 32'hCAFE_CAFE));
    tv.push_back(ld(2'b10, 1'b0, 32'h14, 5'd11, 32'hCAFE_0000, 10'd5));
    tv.push_back(nm(32'h0000_1234, 5'd12));
    tv.push_back(st(2'b10, 32'h1020, 32'h1122_3344, 5'd13, 10'd8, 4'hF, 32'h1122_3344));
    tv.push_back(ld(2'b10, 1'b0, 32'h20, 5'd14, 32'h1122_3344, 10'd8));
    tv.push_back(st(2'b11, 32'h24, 32'h5566_7788, 5'd15, 10'd9, 4'hF, 32'h5566_7788));
    tv.push_back(ld(2'b11, 1'b1, 32'h24, 5'd16, 32'h5566_7788, 10'd9));
    tv.push_back(st(2'b10, 32'h00, 32'h0BAD_F00D, 5'd17, 10'd0, 4'hF, 32'h0BAD_F00D));
`ifdef MEM_ALIGN_CHECK_EN
    tv.push_back(mis(1'b1, 1'b0, 2'b10, 32'h02, 32'h0, 5'd18));
    tv.push_back(mis(1'b0, 1'b1, 2'b01, 32'h01, 32'h0000_BEEF, 5'd19));
    tv.push_back(ld(2'b10, 1'b0, 32'h00, 5'd20, 32'h0BAD_F00D, 10'd0));
`else
    tv.push_back(ld(2'b10, 1'b0, 32'h02, 5'd18, 32'h0BAD_F00D, 10'd0));
    tv.push_back(st(2'b01, 32'h01, 32'h0000_BEEF, 5'd19, 10'd0, 4'h3, 32'hBEEF_BEEF));
    tv.push_back(ld(2'b10, 1'b0, 32'h00, 5'd20, 32'h0BAD_BEEF, 10'd0));
`endif
    tv.push_back(st(2'b00, 32'h31, 32'h0000_007F, 5'd21, 10'd12, 4'h2, 32'h7F7F_7F7F));
    tv.push_back(ld(2'b00, 1'b1, 32'h31, 5'd22, 32'h0000_007F, 10'd12));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_re", {31'b0, ram_re}, 32'd0);
    chk("rst_ram_be", {28'b0, ram_be}, 32'd0);
    chk("rst_ram_addr", {22'b0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    foreach (tv[i]) run_txn(tv[i]);

    // Pass-through with writeback stalled: result must hold and no RAM strobe.
    begin
      exp_t e;
      in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'b10;
      alu_result = 32'h0000_1234; rd_in = 5'd23; out_ready = 1'b0;
      e.data = 32'h0000_1234; e.rd = 5'd23; e.mis = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chk($sformatf("stall_valid_c%0d", k), {31'b0, out_valid}, 32'd1);
        chk($sformatf("stall_data_c%0d", k), out_data, 32'h0000_1234);
        chk($sformatf("stall_in_ready_c%0d", k), {31'b0, in_ready}, 32'd0);
        chk($sformatf("stall_strobe_c%0d", k), {30'b0, ram_we, ram_re}, 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_post_valid", {31'b0, out_valid}, 32'd0);
      chk("stall_post_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end

    // Reset asserted while the load is in ACCESS: transaction is dropped.
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; sign_ext = 1'b0;
    alu_result = 32'h40; rd_in = 5'd31; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("midrst_access_re", {31'b0, ram_re}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_ram_re", {31'b0, ram_re}, 32'd0);
    chk("midrst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("midrst_ram_addr", {22'b0, ram_addr}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_no_strobe", {30'b0, ram_we, ram_re}, 32'd0);
    chk("midrst_no_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    run_txn(ld(2'b10, 1'b0, 32'h24, 5'd24, 32'h5566_7788, 10'd9));

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
